// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line buffer.
// The sprite engine writes one scanline into the write bank through a 2-stage
// read-compare-write pipeline. The display stage reads the other bank and
// clears each location as it reads it. After reset both banks are swept to the
// transparent code before writes are accepted. A bank swap waits until the
// write pipeline has drained.
module sprite_line_buffer #(
  parameter int unsigned      PIX_W      = 4,
  parameter int unsigned      ADDR_W     = 9,
  parameter logic [PIX_W-1:0] TRANSP     = '1,
  parameter bit               FIRST_WINS = 1'b0
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              line_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_x,
  input  logic [PIX_W-1:0]  wr_pix,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_x,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_pix,
  output logic              collision,
  output logic              bank,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              swap_pending;

  logic [PIX_W-1:0]  mem0 [DEPTH];
  logic [PIX_W-1:0]  mem1 [DEPTH];

  // S1: accepted beat, RAM read in flight
  logic              s1_v;
  logic              s1_bank;
  logic [ADDR_W-1:0] s1_x;
  logic [PIX_W-1:0]  s1_pix;
  // S2: beat plus existing pixel, compare and write
  logic              s2_v;
  logic              s2_bank;
  logic [ADDR_W-1:0] s2_x;
  logic [PIX_W-1:0]  s2_pix;
  logic [PIX_W-1:0]  s2_old;

  logic              acc;
  logic              rd_run;
  logic              s2_new_opaque;
  logic              s2_old_opaque;
  logic              s2_we;
  logic [PIX_W-1:0]  s2_final;
  logic [PIX_W-1:0]  s1_ram;
  logic [PIX_W-1:0]  s1_fwd;
  logic [PIX_W-1:0]  disp_ram;

  // Datapath decode: S2 write decision, S1 forwarding, display-bank read
  always_comb begin
    acc           = wr_valid & wr_ready;
    rd_run        = rd_en & (state == RUN);
    s2_new_opaque = (s2_pix != TRANSP);
    s2_old_opaque = (s2_old != TRANSP);
    s2_we         = s2_v & s2_new_opaque & (~s2_old_opaque | ~FIRST_WINS);
    s2_final      = s2_we ? s2_pix : s2_old;
    s1_ram        = s1_bank ? mem1[s1_x] : mem0[s1_x];
    // S2's resolved value overrides the stale RAM word so that back-to-back
    // beats to one address behave as if serialised.
    s1_fwd        = (s2_v && (s2_bank == s1_bank) && (s2_x == s1_x)) ? s2_final : s1_ram;
    disp_ram      = bank ? mem0[rd_x] : mem1[rd_x];
  end

  // Bank RAMs: clear sweep, pipeline write to the write bank, clear-after-read
  // on the display bank (the two RUN writers always target different banks)
  always_ff @(posedge pclk) begin
    if (state == CLEAR) begin
      mem0[clr_addr] <= TRANSP;
      mem1[clr_addr] <= TRANSP;
    end else begin
      if (s2_we) begin
        if (s2_bank) mem1[s2_x] <= s2_pix;
        else         mem0[s2_x] <= s2_pix;
      end
      if (rd_run) begin
        if (bank) mem0[rd_x] <= TRANSP;
        else      mem1[rd_x] <= TRANSP;
      end
    end
  end

  // Write pipeline, collision flag and display read port
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      s1_v      <= 1'b0;
      s1_bank   <= 1'b0;
      s1_x      <= '0;
      s1_pix    <= TRANSP;
      s2_v      <= 1'b0;
      s2_bank   <= 1'b0;
      s2_x      <= '0;
      s2_pix    <= TRANSP;
      s2_old    <= TRANSP;
      collision <= 1'b0;
      rd_valid  <= 1'b0;
      rd_pix    <= TRANSP;
    end else begin
      s1_v <= acc;
      if (acc) begin
        s1_bank <= bank;
        s1_x    <= wr_x;
        s1_pix  <= wr_pix;
      end
      s2_v      <= s1_v;
      s2_bank   <= s1_bank;
      s2_x      <= s1_x;
      s2_pix    <= s1_pix;
      s2_old    <= s1_fwd;
      collision <= s2_v & s2_new_opaque & s2_old_opaque;
      rd_valid  <= rd_run;
      if (rd_run) rd_pix <= disp_ram;
    end
  end

  // Control FSM: post-reset clear sweep, then deferred bank swapping
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state        <= CLEAR;
      clr_addr     <= '0;
      swap_pending <= 1'b0;
      bank         <= 1'b0;
      wr_ready     <= 1'b0;
      busy         <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state    <= RUN;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        RUN: begin
          if (swap_pending && !s1_v && !s2_v) begin
            bank         <= ~bank;
            swap_pending <= 1'b0;
            wr_ready     <= 1'b1;
            busy         <= 1'b0;
          end else if (line_start) begin
            swap_pending <= 1'b1;
            wr_ready     <= 1'b0;
            busy         <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Bench for sprite_line_buffer: two instances (last-wins and first-wins)
// share one stimulus stream; a scoreboard queues expected collisions and
// read data as stimulus is driven and checks them when they fall due.
module tb_sprite_line_buffer;

  localparam logic [3:0] TR = 4'hF;

  logic       pclk;
  logic       reset;
  logic       line_start;
  logic       wr_valid;
  logic [8:0] wr_x;
  logic [3:0] wr_pix;
  logic       rd_en;
  logic [8:0] rd_x;

  logic       wr_ready0, rd_valid0, collision0, bank0, busy0;
  logic [3:0] rd_pix0;
  logic       wr_ready1, rd_valid1, collision1, bank1, busy1;
  logic [3:0] rd_pix1;

  sprite_line_buffer #(.PIX_W(4), .ADDR_W(9), .TRANSP(4'hF), .FIRST_WINS(1'b0)) dut0 (
    .pclk(pclk), .reset(reset), .line_start(line_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_x(wr_x), .wr_pix(wr_pix),
    .rd_en(rd_en), .rd_x(rd_x), .rd_valid(rd_valid0), .rd_pix(rd_pix0),
    .collision(collision0), .bank(bank0), .busy(busy0)
  );

  sprite_line_buffer #(.PIX_W(4), .ADDR_W(9), .TRANSP(4'hF), .FIRST_WINS(1'b1)) dut1 (
    .pclk(pclk), .reset(reset), .line_start(line_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_x(wr_x), .wr_pix(wr_pix),
    .rd_en(rd_en), .rd_x(rd_x), .rd_valid(rd_valid1), .rd_pix(rd_pix1),
    .collision(collision1), .bank(bank1), .busy(busy1)
  );

  typedef struct { logic [8:0] x; logic [3:0] pix; logic coll; } wr_vec_t;
  typedef struct { logic [8:0] x; logic [3:0] e0; logic [3:0] e1; } rd_vec_t;
  typedef struct { int due; logic c; } coll_ent_t;
  typedef struct { int due; logic [3:0] e0; logic [3:0] e1; } rd_ent_t;

  int         vectors;
  int         miscompares;
  int         ncyc;
  logic       exp_coll;
  logic [3:0] exp_rd0, exp_rd1;
  logic       rd_track;
  logic       exp_bank;
  coll_ent_t  col_q[$];
  rd_ent_t    rd_q[$];

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: check what is due this cycle, then record new stimulus
  always @(negedge pclk) begin
    if (col_q.size() > 0 && col_q[0].due == ncyc) begin
      chk("collision_lw", collision0, col_q[0].c);
      chk("collision_fw", collision1, col_q[0].c);
      void'(col_q.pop_front());
    end else if (collision0 || collision1) begin
      chk("spurious_collision", {collision0, collision1}, 0);
    end
    if (rd_q.size() > 0 && rd_q[0].due == ncyc) begin
      chk("rd_valid_lw", rd_valid0, 1);
      chk("rd_valid_fw", rd_valid1, 1);
      chk("rd_pix_lw", rd_pix0, rd_q[0].e0);
      chk("rd_pix_fw", rd_pix1, rd_q[0].e1);
      void'(rd_q.pop_front());
    end else if (rd_valid0 || rd_valid1) begin
      chk("spurious_rd_valid", {rd_valid0, rd_valid1}, 0);
    end
    if (!reset && wr_valid && wr_ready0) col_q.push_back('{due: ncyc + 3, c: exp_coll});
    if (!reset && rd_en && rd_track) rd_q.push_back('{due: ncyc + 1, e0: exp_rd0, e1: exp_rd1});
    ncyc++;
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_wr_ready", {wr_ready0, wr_ready1}, 0);
    chk("rst_rd_valid", {rd_valid0, rd_valid1}, 0);
    chk("rst_rd_pix", {rd_pix0, rd_pix1}, {TR, TR});
    chk("rst_collision", {collision0, collision1}, 0);
    chk("rst_bank", {bank0, bank1}, 0);
    chk("rst_busy", {busy0, busy1}, 2'b11);
  endtask

  // Release reset, count busy cycles of the sweep, poke line_start/rd_en mid-sweep
  task automatic release_and_sweep();
    int cnt0 = 0;
    int cnt1 = 0;
    reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge pclk);
      if (i == 100) begin line_start = 1'b1; rd_en = 1'b1; rd_x = 9'd7; end
      if (i == 101) begin line_start = 1'b0; rd_en = 1'b0; end
      if (!busy0 && !busy1) break;
      if (busy0) cnt0++;
      if (busy1) cnt1++;
    end
    chk("clear_busy_cycles_lw", cnt0, 512);
    chk("clear_busy_cycles_fw", cnt1, 512);
    step();
    exp_bank = 1'b0;
    chk("post_clear_bank", {bank0, bank1}, 0);
    chk("post_clear_busy", {busy0, busy1}, 0);
    chk("post_clear_wr_ready", {wr_ready0, wr_ready1}, 2'b11);
  endtask

  task automatic swap();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    for (int i = 0; i < 20 && busy0; i++) step();
    chk("swap_done", busy0, 0);
    exp_bank = ~exp_bank;
    chk("swap_bank_lw", bank0, exp_bank);
    chk("swap_bank_fw", bank1, exp_bank);
  endtask

  task automatic read_all();
    rd_track = 1'b1;
    exp_rd0 = TR;
    exp_rd1 = TR;
    for (int i = 0; i < 512; i++) begin
      rd_en = 1'b1;
      rd_x  = 9'(i);
      step();
    end
    rd_en = 1'b0;
    step();
    step();
  endtask

  task automatic write_beat(input logic [8:0] x, input logic [3:0] pix, input logic c);
    wr_valid = 1'b1;
    wr_x     = x;
    wr_pix   = pix;
    exp_coll = c;
    step();
  endtask

  wr_vec_t wtab[10];
  rd_vec_t rtab[10];

  initial begin
    vectors = 0; miscompares = 0; ncyc = 0;
    reset = 1'b1; line_start = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_pix = TR;
    rd_en = 1'b0; rd_x = '0; exp_coll = 1'b0; exp_rd0 = TR; exp_rd1 = TR;
    rd_track = 1'b0; exp_bank = 1'b0;

    // write stream; collision expected on the second opaque hit of a location
    wtab[0] = '{x: 9'd10,  pix: 4'd3, coll: 1'b0};
    wtab[1] = '{x: 9'd10,  pix: 4'd5, coll: 1'b1};
    wtab[2] = '{x: 9'd511, pix: 4'd2, coll: 1'b0};
    wtab[3] = '{x: 9'd511, pix: 4'd7, coll: 1'b1};
    wtab[4] = '{x: 9'd511, pix: TR,   coll: 1'b0};
    wtab[5] = '{x: 9'd0,   pix: 4'd9, coll: 1'b0};
    wtab[6] = '{x: 9'd20,  pix: TR,   coll: 1'b0};
    wtab[7] = '{x: 9'd30,  pix: 4'd4, coll: 1'b0};
    wtab[8] = '{x: 9'd30,  pix: TR,   coll: 1'b0};
    wtab[9] = '{x: 9'd30,  pix: 4'd6, coll: 1'b1};
    // reads after swap: e0 = last-wins, e1 = first-wins; repeats read cleared data
    rtab[0] = '{x: 9'd10,  e0: 4'd5, e1: 4'd3};
    rtab[1] = '{x: 9'd10,  e0: TR,   e1: TR};
    rtab[2] = '{x: 9'd511, e0: 4'd7, e1: 4'd2};
    rtab[3] = '{x: 9'd0,   e0: 4'd9, e1: 4'd9};
    rtab[4] = '{x: 9'd511, e0: TR,   e1: TR};
    rtab[5] = '{x: 9'd30,  e0: 4'd6, e1: 4'd4};
    rtab[6] = '{x: 9'd20,  e0: TR,   e1: TR};
    rtab[7] = '{x: 9'd0,   e0: TR,   e1: TR};
    rtab[8] = '{x: 9'd1,   e0: TR,   e1: TR};
    rtab[9] = '{x: 9'd29,  e0: TR,   e1: TR};

    repeat (3) step();
    check_reset_values();
    release_and_sweep();

    // reset while writes are in flight
    write_beat(9'd5, 4'd3, 1'b0);
    write_beat(9'd6, 4'd4, 1'b0);
    wr_valid = 1'b0;
    reset = 1'b1;
    col_q.delete();
    rd_q.delete();
    #1;
    check_reset_values();
    step();
    step();
    release_and_sweep();

    // every address of both banks is transparent, across two swaps
    read_all();
    swap();
    read_all();
    swap();
    read_all();

    // write stream into a clean bank, then swap and read back
    foreach (wtab[i]) write_beat(wtab[i].x, wtab[i].pix, wtab[i].coll);
    wr_valid = 1'b0;
    repeat (4) step();
    swap();
    rd_track = 1'b1;
    foreach (rtab[i]) begin
      rd_en   = 1'b1;
      rd_x    = rtab[i].x;
      exp_rd0 = rtab[i].e0;
      exp_rd1 = rtab[i].e1;
      step();
    end
    rd_en = 1'b0;
    repeat (3) step();

    // deferred swap: line_start right after two beats
    write_beat(9'd100, 4'd1, 1'b0);
    write_beat(9'd101, 4'd2, 1'b0);
    wr_valid   = 1'b0;
    line_start = 1'b1;
    step();
    chk("defer_bank_c0", bank0, exp_bank);
    chk("defer_wr_ready_c0", wr_ready0, 0);
    chk("defer_busy_c0", busy0, 1);
    step();
    chk("defer_bank_c1", {bank0, bank1}, {exp_bank, exp_bank});
    chk("defer_wr_ready_c1", {wr_ready0, wr_ready1}, 0);
    chk("defer_busy_c1", busy0, 1);
    line_start = 1'b0;
    step();
    exp_bank = ~exp_bank;
    chk("defer_bank_c2", {bank0, bank1}, {exp_bank, exp_bank});
    chk("defer_wr_ready_c2", {wr_ready0, wr_ready1}, 2'b11);
    chk("defer_busy_c2", busy0, 0);
    repeat (3) step();
    chk("no_double_swap", {bank0, bank1}, {exp_bank, exp_bank});
    rd_en = 1'b1; rd_x = 9'd100; exp_rd0 = 4'd1; exp_rd1 = 4'd1;
    step();
    rd_x = 9'd101; exp_rd0 = 4'd2; exp_rd1 = 4'd2;
    step();
    rd_en = 1'b0;

    for (int i = 0; i < 10 && (col_q.size() > 0 || rd_q.size() > 0); i++) step();
    chk("scoreboard_drained", col_q.size() + rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
